m2m_control_fsm: RTL and testbench
==================================

Name: m2m_control_fsm

Overview:
- Multi-cycle control unit that sits directly upstream of the stage_4 datapath.
- Consumes the datapath's opcode byte (Opout) and branch flag (isTrue).
- Drives every datapath write-enable and mux select, one state per clock, to sequence memory-to-memory instructions.
- Instruction format is four consecutive words: opcode word (opcode in low 8 bits as latched by the Op register), A-address, B-address, Dest-address. HALT is a single word.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (sampled on CLK rising edge; 0 = reset).
- run  in  1  start request; leaves IDLE when 1.
- Opout  in  8  opcode from the datapath Op register.
- isTrue  in  1  ALU condition flag from the datapath.
- inputPC  out  1  PC source: 0 = ALU, 1 = A reg.
- WEpc  out  1  PC write enable.
- normOrBranch  out  1  0 = normal PC path, 1 = branch target (Dest reg).
- ALUsrca  out  2  0 = A reg, 1 = PC, 2 = ext.
- ALUsrcb  out  2  0 = B reg, 1 = constant 1.
- ALUOp  out  4  ALU function; 0 = ADD.
- writeA, writeB, writeDest, writeOp  out  1 each  register write enables.
- valA  out  1  A source: 0 = memOut, 1 = ALU.
- memAddr  out  2  0 = A, 1 = B, 2 = Dest, 3 = MA3.
- regOrPC  out  1  memory address: 0 = PC, 1 = memAddr mux.
- writeMem  out  1  memory write enable.
- memWriteData  out  2  0 = B, 1 = ALU, 2 = A.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set on undefined opcode.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (reset=0 at an edge): state := IDLE, retired := 0, halted := 0, illegal := 0. Applies from any state, including mid-instruction; no memory or PC write occurs in that cycle.
- Default outputs: all control outputs are 0 in every state unless listed below. All outputs are decoded combinationally from the registered state and Opout.
- "PC+1 bundle": regOrPC=0, ALUsrca=1, ALUsrcb=1, ALUOp=0, inputPC=0, normOrBranch=0, WEpc=1.
- Opcode classes from Opout[7:4]:
  - 0x0 ALU: function = Opout[3:0].
  - 0x1 conditional branch: compare function = Opout[3:0].
  - 0x2 jump.
  - 0xF halt.
  - Any other value is illegal.
- States (one cycle each):
  - IDLE: outputs 0; go to FETCH_OP if run=1, else stay.
  - FETCH_OP: PC+1 bundle, writeOp=1. Next FETCH_A.
  - FETCH_A: decode the now-valid Opout. If 0xF, go to HALT with no writes. If illegal, set illegal and go to HALT with no writes. Otherwise PC+1 bundle, writeA=1, valA=0; next FETCH_B.
  - FETCH_B: PC+1 bundle, writeB=1. Next FETCH_D.
  - FETCH_D: PC+1 bundle, writeDest=1. Next JUMP if class 0x2, else LOAD_A.
  - LOAD_A: regOrPC=1, memAddr=0, writeA=1, valA=0. Next LOAD_B.
  - LOAD_B: regOrPC=1, memAddr=1, writeB=1. Next EXEC (class 0x0) or BRANCH (class 0x1).
  - EXEC: ALUsrca=0, ALUsrcb=0, ALUOp=Opout[3:0], regOrPC=1, memAddr=2, memWriteData=1, writeMem=1. retired += 1. Next FETCH_OP.
  - BRANCH: ALUsrca=0, ALUsrcb=0, ALUOp=Opout[3:0]. If isTrue=1: WEpc=1, normOrBranch=1 (PC := Dest). retired += 1. Next FETCH_OP.
  - JUMP: WEpc=1, normOrBranch=1. retired += 1. Next FETCH_OP.
  - HALT: halted=1, all enables 0; stay until reset. run is ignored.
- Latency: ALU and branch instructions take 7 cycles; jump takes 5 cycles; halt takes 2 cycles to reach HALT. Halt is not counted in retired.
- retired wraps from 2^CNT_W-1 to 0 without a flag.
- At most one write enable among writeA/writeB/writeDest/writeOp is high in any cycle.
- writeMem is high only in EXEC.

Test Plan:
- Reset held low 3 cycles, then high with run=0 -> state IDLE, all outputs 0, retired=0; stays IDLE for 10 cycles.
- run=1, memory at 0 holds ALU ADD (Opout=0x00), A=10, B=11, D=12 -> exactly one writeMem pulse, in cycle 7 with memAddr=2, memWriteData=1; WEpc high in cycles 1-4 only; retired=1.
- Branch Opout=0x13: with isTrue=1, BRANCH cycle has WEpc=1 and normOrBranch=1; with isTrue=0, WEpc=0 in BRANCH. retired increments in both cases.
- Jump Opout=0x20 -> JUMP reached after FETCH_D (cycle 5) with WEpc=1 and normOrBranch=1; LOAD_A never entered.
- Opout=0xF0 -> halted=1 from cycle 3 onward, retired unchanged. Opout=0x50 -> illegal=1 and halted=1. Pulsing run while halted has no effect.
- Reset asserted during LOAD_B -> next cycle IDLE, writeMem never pulses, retired=0. Preload retired to 0xFFFF, retire one instruction -> retired=0x0000.

Source files
------------

// File: rtl/m2m_control_fsm.sv
// Multi-cycle sequencer for memory-to-memory instructions on the stage_4 datapath.
// Walks opcode/A/B/Dest fetches, operand loads and execute, one state per clock.
module m2m_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  input  logic [7:0]       Opout,
  input  logic             isTrue,
  output logic             inputPC,
  output logic             WEpc,
  output logic             normOrBranch,
  output logic [1:0]       ALUsrca,
  output logic [1:0]       ALUsrcb,
  output logic [3:0]       ALUOp,
  output logic             writeA,
  output logic             writeB,
  output logic             writeDest,
  output logic             writeOp,
  output logic             valA,
  output logic [1:0]       memAddr,
  output logic             regOrPC,
  output logic             writeMem,
  output logic [1:0]       memWriteData,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH_OP = 4'd1,
    S_FETCH_A  = 4'd2,
    S_FETCH_B  = 4'd3,
    S_FETCH_D  = 4'd4,
    S_LOAD_A   = 4'd5,
    S_LOAD_B   = 4'd6,
    S_EXEC     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  logic [3:0] op_class;
  logic       cls_alu, cls_br, cls_jmp, cls_halt, cls_ill;

  logic pc_inc;
  logic we_pc, we_a, we_b, we_d, we_op, we_mem;

  assign op_class = Opout[7:4];
  assign cls_alu  = (op_class == 4'h0);
  assign cls_br   = (op_class == 4'h1);
  assign cls_jmp  = (op_class == 4'h2);
  assign cls_halt = (op_class == 4'hF);
  assign cls_ill  = !(cls_alu || cls_br || cls_jmp || cls_halt);

  always_comb begin
    state_d      = state_q;
    retired_d    = retired_q;
    illegal_d    = illegal_q;
    pc_inc       = 1'b0;
    inputPC      = 1'b0;
    normOrBranch = 1'b0;
    ALUsrca      = 2'd0;
    ALUsrcb      = 2'd0;
    ALUOp        = 4'd0;
    valA         = 1'b0;
    memAddr      = 2'd0;
    regOrPC      = 1'b0;
    memWriteData = 2'd0;
    we_pc        = 1'b0;
    we_a         = 1'b0;
    we_b         = 1'b0;
    we_d         = 1'b0;
    we_op        = 1'b0;
    we_mem       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH_OP;
      end

      S_FETCH_OP: begin
        pc_inc  = 1'b1;
        we_op   = 1'b1;
        state_d = S_FETCH_A;
      end

      // Opout only becomes valid here, so halt/illegal are caught before any A write.
      S_FETCH_A: begin
        if (cls_halt) begin
          state_d = S_HALT;
        end else if (cls_ill) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          pc_inc  = 1'b1;
          we_a    = 1'b1;
          valA    = 1'b0;
          state_d = S_FETCH_B;
        end
      end

      S_FETCH_B: begin
        pc_inc  = 1'b1;
        we_b    = 1'b1;
        state_d = S_FETCH_D;
      end

      S_FETCH_D: begin
        pc_inc  = 1'b1;
        we_d    = 1'b1;
        state_d = cls_jmp ? S_JUMP : S_LOAD_A;
      end

      S_LOAD_A: begin
        regOrPC = 1'b1;
        memAddr = 2'd0;
        we_a    = 1'b1;
        valA    = 1'b0;
        state_d = S_LOAD_B;
      end

      S_LOAD_B: begin
        regOrPC = 1'b1;
        memAddr = 2'd1;
        we_b    = 1'b1;
        state_d = cls_alu ? S_EXEC : S_BRANCH;
      end

      S_EXEC: begin
        ALUsrca      = 2'd0;
        ALUsrcb      = 2'd0;
        ALUOp        = Opout[3:0];
        regOrPC      = 1'b1;
        memAddr      = 2'd2;
        memWriteData = 2'd1;
        we_mem       = 1'b1;
        retired_d    = retired_q + CNT_W'(1);
        state_d      = S_FETCH_OP;
      end

      S_BRANCH: begin
        ALUsrca   = 2'd0;
        ALUsrcb   = 2'd0;
        ALUOp     = Opout[3:0];
        if (isTrue) begin
          we_pc        = 1'b1;
          normOrBranch = 1'b1;
        end
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH_OP;
      end

      S_JUMP: begin
        we_pc        = 1'b1;
        normOrBranch = 1'b1;
        retired_d    = retired_q + CNT_W'(1);
        state_d      = S_FETCH_OP;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pc_inc) begin
      ALUsrca = 2'd1;
      ALUsrcb = 2'd1;
      ALUOp   = 4'd0;
      we_pc   = 1'b1;
    end
  end

  // Enables are masked while reset is low so an aborted instruction writes nothing.
  assign WEpc      = we_pc  & reset;
  assign writeA    = we_a   & reset;
  assign writeB    = we_b   & reset;
  assign writeDest = we_d   & reset;
  assign writeOp   = we_op  & reset;
  assign writeMem  = we_mem & reset;

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_m2m_control_fsm.sv
// Randomized bench for m2m_control_fsm against an instruction-level timing model.
// A second narrow-counter instance shares the stimulus to exercise retired wrap.
module tb_m2m_control_fsm;

  localparam int K_ALU = 0, K_BR = 1, K_JMP = 2, K_HALT = 3, K_ILL = 4;

  typedef struct packed {
    logic       inputPC;
    logic       WEpc;
    logic       normOrBranch;
    logic [1:0] ALUsrca;
    logic [1:0] ALUsrcb;
    logic [3:0] ALUOp;
    logic       writeA;
    logic       writeB;
    logic       writeDest;
    logic       writeOp;
    logic       valA;
    logic [1:0] memAddr;
    logic       regOrPC;
    logic       writeMem;
    logic [1:0] memWriteData;
    logic       halted;
  } ctrl_t;

  logic        CLK = 1'b0;
  logic        reset, run, isTrue;
  logic [7:0]  Opout;

  logic        inputPC, WEpc, normOrBranch, writeA, writeB, writeDest, writeOp;
  logic        valA, regOrPC, writeMem, halted, illegal;
  logic [1:0]  ALUsrca, ALUsrcb, memAddr, memWriteData;
  logic [3:0]  ALUOp;
  logic [15:0] retired;

  logic        inputPC_s, WEpc_s, normOrBranch_s, writeA_s, writeB_s, writeDest_s, writeOp_s;
  logic        valA_s, regOrPC_s, writeMem_s, halted_s, illegal_s;
  logic [1:0]  ALUsrca_s, ALUsrcb_s, memAddr_s, memWriteData_s;
  logic [3:0]  ALUOp_s;
  logic [2:0]  retired_s;

  ctrl_t obs, obs_s;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] ret_cnt = 0;
  logic        ill_flag = 1'b0;

  always #5 CLK = ~CLK;

  m2m_control_fsm #(.CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .run(run), .Opout(Opout), .isTrue(isTrue),
    .inputPC(inputPC), .WEpc(WEpc), .normOrBranch(normOrBranch),
    .ALUsrca(ALUsrca), .ALUsrcb(ALUsrcb), .ALUOp(ALUOp),
    .writeA(writeA), .writeB(writeB), .writeDest(writeDest), .writeOp(writeOp),
    .valA(valA), .memAddr(memAddr), .regOrPC(regOrPC), .writeMem(writeMem),
    .memWriteData(memWriteData), .halted(halted), .illegal(illegal), .retired(retired)
  );

  m2m_control_fsm #(.CNT_W(3)) dut_w3 (
    .CLK(CLK), .reset(reset), .run(run), .Opout(Opout), .isTrue(isTrue),
    .inputPC(inputPC_s), .WEpc(WEpc_s), .normOrBranch(normOrBranch_s),
    .ALUsrca(ALUsrca_s), .ALUsrcb(ALUsrcb_s), .ALUOp(ALUOp_s),
    .writeA(writeA_s), .writeB(writeB_s), .writeDest(writeDest_s), .writeOp(writeOp_s),
    .valA(valA_s), .memAddr(memAddr_s), .regOrPC(regOrPC_s), .writeMem(writeMem_s),
    .memWriteData(memWriteData_s), .halted(halted_s), .illegal(illegal_s), .retired(retired_s)
  );

  assign obs = {inputPC, WEpc, normOrBranch, ALUsrca, ALUsrcb, ALUOp, writeA, writeB,
                writeDest, writeOp, valA, memAddr, regOrPC, writeMem, memWriteData, halted};
  assign obs_s = {inputPC_s, WEpc_s, normOrBranch_s, ALUsrca_s, ALUsrcb_s, ALUOp_s, writeA_s,
                  writeB_s, writeDest_s, writeOp_s, valA_s, memAddr_s, regOrPC_s, writeMem_s,
                  memWriteData_s, halted_s};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle k (1-based) of an instruction: four word fetches, two operand loads, then the action.
  function automatic ctrl_t exp_ctrl(input int kind, input logic [3:0] fn, input int k,
                                     input logic t);
    ctrl_t c;
    c = '0;
    if (kind == K_HALT || kind == K_ILL) begin
      if (k == 1) begin
        c.WEpc = 1'b1; c.ALUsrca = 2'd1; c.ALUsrcb = 2'd1; c.writeOp = 1'b1;
      end else if (k >= 3) begin
        c.halted = 1'b1;
      end
    end else if (k <= 4) begin
      c.WEpc = 1'b1; c.ALUsrca = 2'd1; c.ALUsrcb = 2'd1;
      c.writeOp   = (k == 1);
      c.writeA    = (k == 2);
      c.writeB    = (k == 3);
      c.writeDest = (k == 4);
    end else if (kind == K_JMP) begin
      c.WEpc = 1'b1; c.normOrBranch = 1'b1;
    end else if (k == 5) begin
      c.regOrPC = 1'b1; c.memAddr = 2'd0; c.writeA = 1'b1;
    end else if (k == 6) begin
      c.regOrPC = 1'b1; c.memAddr = 2'd1; c.writeB = 1'b1;
    end else if (kind == K_ALU) begin
      c.ALUOp = fn; c.regOrPC = 1'b1; c.memAddr = 2'd2;
      c.memWriteData = 2'd1; c.writeMem = 1'b1;
    end else begin
      c.ALUOp = fn;
      c.WEpc = t; c.normOrBranch = t;
    end
    return c;
  endfunction

  task automatic cycle(input logic [7:0] op, input int kind, input int k, input int tmode);
    ctrl_t e;
    logic  exp_ill;
    @(posedge CLK); #1;
    Opout  = op;
    run    = 1'($urandom);
    isTrue = (tmode < 0) ? 1'($urandom) : 1'(tmode);
    #1;
    e = exp_ctrl(kind, op[3:0], k, isTrue);
    exp_ill = ill_flag | ((kind == K_ILL) && (k >= 3));
    chk($sformatf("ctrl op%02h k%0d", op, k), 32'(obs), 32'(e));
    chk($sformatf("ctrl_w3 op%02h k%0d", op, k), 32'(obs_s), 32'(e));
    chk("retired", 32'(retired), 32'(ret_cnt[15:0]));
    chk("retired_w3", 32'(retired_s), 32'(ret_cnt[2:0]));
    chk("illegal", 32'(illegal), 32'(exp_ill));
    chk("onehot_we", 32'($countones({writeA, writeB, writeDest, writeOp}) <= 1), 32'd1);
  endtask

  task automatic run_instr(input logic [7:0] op, input int kind, input int tmode);
    int n;
    n = (kind == K_JMP) ? 5 : ((kind <= K_BR) ? 7 : 8);
    for (int k = 1; k <= n; k++) cycle(op, kind, k, tmode);
    if (kind <= K_JMP) ret_cnt++;
    if (kind == K_ILL) ill_flag = 1'b1;
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_ctrl"}, 32'(obs), 32'd0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    reset = 1'b0; run = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b1;
    ret_cnt = 0;
    ill_flag = 1'b0;
    #1;
    idle_check("post_reset");
  endtask

  task automatic start();
    @(posedge CLK); #1;
    run = 1'b1;
    #1;
    chk("idle_run_ctrl", 32'(obs), 32'd0);
  endtask

  initial begin
    logic [7:0] op;
    int         kind;
    reset = 1'b0; run = 1'b0; Opout = 8'h00; isTrue = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b1;
    #1 idle_check("reset_release");
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      run = 1'b0;
      #1 idle_check("idle_hold");
    end

    start();
    run_instr(8'h00, K_ALU, -1);
    run_instr(8'h13, K_BR, 1);
    run_instr(8'h13, K_BR, 0);
    run_instr(8'h20, K_JMP, -1);
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 2));
      op   = {4'(kind), 4'($urandom)};
      run_instr(op, kind, -1);
    end

    run_instr(8'hF0, K_HALT, -1);

    do_reset();
    start();
    run_instr(8'h05, K_ALU, -1);
    op = {4'($urandom_range(3, 14)), 4'($urandom)};
    run_instr(op, K_ILL, -1);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      run = ~run;
      #1;
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("ill_sticky", 32'(illegal), 32'd1);
      chk("halt_retired", 32'(retired), 32'(ret_cnt[15:0]));
    end

    do_reset();
    start();
    for (int k = 1; k <= 5; k++) cycle(8'h07, K_ALU, k, -1);
    @(posedge CLK); #1;
    reset = 1'b0; run = 1'b0;
    #1;
    chk("abort_writeMem", 32'(writeMem), 32'd0);
    chk("abort_WEpc", 32'(WEpc), 32'd0);
    @(posedge CLK); #1;
    reset = 1'b1;
    ret_cnt = 0;
    ill_flag = 1'b0;
    #1 idle_check("abort_idle");
    start();
    run_instr(8'h2A, K_JMP, -1);
    cycle(8'h00, K_ALU, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
